vsfx_pipe: RTL
==============

Name: vsfx_pipe

Overview:
- Parametrised, pipelined successor to the vector simple fixed-point unit.
- Performs element-wise add/sub (modulo and saturating) and compares on byte/half/word lanes of a VW-bit vector.
- Configurable latency and a valid/ready handshake with back-pressure, so it can sit behind the issue queue and in front of the VR writeback port.
- Produces a per-result SAT, a sticky SAT (VSCR[SAT] model) and CR6 for record-form compares.

Parameters:
- VW, 128, vector width in bits; must be a multiple of 32.
- LAT, 2, pipeline depth in register stages, legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  input valid
- in_ready  out  1  unit can accept an operation this cycle
- vra  in  VW  operand A
- vrb  in  VW  operand B
- ins  in  8  [2:0] op, [4:3] size (00 byte, 01 half, 10 word, 11 reserved), [5] signed compare, [6] record, [7] avg select (see Optional Feature)
- vrt_en  out  1  output valid
- out_ready  in  1  downstream accepts result
- vrt  out  VW  result vector
- sat  out  1  this result saturated
- cr6  out  4  CR6 field for this result
- sat_sticky  out  1  sticky saturation flag
- sat_clr  in  1  clear sat_sticky

Behaviour:
- Reset (async, rst=1): all stage valids=0; vrt=0, vrt_en=0, sat=0, cr6=0, sat_sticky=0.
- Ops on each lane independently, lane width W = 8/16/32:
  - 0 addm: A+B mod 2^W.
  - 1 addus: unsigned saturating add, clamp to 2^W-1.
  - 2 addss: signed saturating add, clamp to [-2^(W-1), 2^(W-1)-1].
  - 3 subm: A-B mod 2^W.
  - 4 subus: unsigned saturating subtract, clamp to 0.
  - 5 subss: signed saturating subtract.
  - 6 cmpeq: lane = all ones if A==B, else 0.
  - 7 cmpgt: lane = all ones if A>B (signed if ins[5], else unsigned), else 0.
- sat = OR over lanes of "clamp applied"; sat is 0 for ops 0, 3, 6, 7.
- cr6:
  - ops 6/7 with ins[6]=1: cr6 = {all lanes true, 0, all lanes false, 0}.
  - Otherwise cr6 = 0.
- Reserved size 11: vrt=0, sat=0, cr6=0; vrt_en is still produced.
- Pipeline:
  - Result is computed combinationally from the accepted inputs and carried through LAT register stages.
  - An op accepted at edge t (en & in_ready) presents vrt_en=1 after edge t+LAT-1, i.e. LAT cycles of latency.
  - Throughput is one op per cycle.
- Handshake:
  - stall = vrt_en & !out_ready; in_ready = !stall.
  - On stall every stage holds and vrt/sat/cr6 stay stable.
  - Bubbles do not collapse during a stall; whole-pipe freeze is sufficient.
  - en while in_ready=0 is ignored; the source must hold its inputs.
- Sticky flag:
  - sat_sticky sets on a cycle where vrt_en & out_ready & sat.
  - sat_clr clears it.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-operation: all in-flight ops are discarded; no partial output.

Optional Feature:
- Macro VSFX_AVG_EN.
  - Defined: ins[7]=1 with op 0 selects average, lane = (A+B+1)>>1 computed at W+1 bits (signed if ins[5], else unsigned); sat=0.
  - Undefined: ins[7] is ignored and op 0 behaves as addm.

Test Plan:
- addus, byte, vra=all 0xFF, vrb=all 0x01, LAT=2 -> vrt=all 0xFF, sat=1, vrt_en exactly 2 cycles after accept; sat_sticky=1 after the accepted output.
- addss, half, vra lanes 0x7FFF, vrb lanes 0x0001 -> lanes 0x7FFF, sat=1; then subm, word, vra=0, vrb=1 -> all 0xFFFFFFFF, sat=0.
- cmpeq record, word, vra=vrb=128'hffffffff00000000ffffffff00000000 -> vrt=all ones, cr6=4'b1000; cmpgt unsigned record, vra=0, same vrb -> vrt=0, cr6=4'b0010.
- Back-to-back ops every cycle, out_ready held low for 3 cycles mid-stream -> in_ready=0 during the stall, vrt stable, no op lost or duplicated, order preserved.
- sat_clr asserted in the same cycle a saturating result is accepted -> sat_sticky=1; sat_clr alone next cycle -> 0; rst with 2 ops in flight -> vrt_en=0 immediately, no outputs afterwards.
- With VSFX_AVG_EN, byte, unsigned, ins[7]=1, op 0, vra=0xFF, vrb=0x00 -> 0x80; without the macro, same stimulus -> 0xFF (addm).

Source files
------------

// File: rtl/vsfx_pipe.sv
// vsfx_pipe: lane-wise modulo/saturating add/sub and compares, LAT-cycle latency, whole pipe freezes while the output is stalled.
// Define VSFX_AVG_EN to turn op 0 with ins[7]=1 into a rounding average.
module vsfx_pipe #(
  parameter int VW  = 128,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          in_ready,
  input  logic [VW-1:0] vra,
  input  logic [VW-1:0] vrb,
  input  logic [7:0]    ins,
  output logic          vrt_en,
  input  logic          out_ready,
  output logic [VW-1:0] vrt,
  output logic          sat,
  output logic [3:0]    cr6,
  output logic          sat_sticky,
  input  logic          sat_clr
);

  // Returns {clamped, lane result}; operands arrive zero-extended in the low w bits.
  function automatic logic [32:0] lane_op(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w, input logic [2:0] op,
                                          input logic sgn, input logic avg);
    logic [33:0]        mask, ua, ub, usum, udif, t;
    logic signed [33:0] sa, sb, ssum, sdif, smax, smin, savg;
    logic               s;
    mask = (34'd1 << w) - 34'd1;
    ua   = {2'b00, a} & mask;
    ub   = {2'b00, b} & mask;
    sa   = $signed(ua << (34 - w)) >>> (34 - w);
    sb   = $signed(ub << (34 - w)) >>> (34 - w);
    smax = $signed(mask >> 1);
    smin = -smax - 34'sd1;
    usum = ua + ub;
    udif = ua - ub;
    ssum = sa + sb;
    sdif = sa - sb;
    savg = (ssum + 34'sd1) >>> 1;
    s    = 1'b0;
    t    = '0;
    case (op)
      3'd0: begin
        if (avg) t = sgn ? savg : ((usum + 34'd1) >> 1);
        else     t = usum;
      end
      3'd1: begin
        if (usum > mask) begin t = mask; s = 1'b1; end
        else t = usum;
      end
      3'd2: begin
        if (ssum > smax)      begin t = smax; s = 1'b1; end
        else if (ssum < smin) begin t = smin; s = 1'b1; end
        else t = ssum;
      end
      3'd3: t = udif;
      3'd4: begin
        if (ua < ub) begin t = '0; s = 1'b1; end
        else t = udif;
      end
      3'd5: begin
        if (sdif > smax)      begin t = smax; s = 1'b1; end
        else if (sdif < smin) begin t = smin; s = 1'b1; end
        else t = sdif;
      end
      3'd6: t = (ua == ub) ? mask : '0;
      default: t = ((sgn && (sa > sb)) || (!sgn && (ua > ub))) ? mask : '0;
    endcase
    return {s, 32'(t & mask)};
  endfunction

  logic          avg_sel;
`ifdef VSFX_AVG_EN
  assign avg_sel = ins[7];
`else
  logic avg_unused;
  assign avg_unused = ins[7];
  assign avg_sel    = 1'b0;
`endif

  logic [VW-1:0] res_d;
  logic          sat_d;
  logic [3:0]    cr6_d;
  logic          all_t, all_f;
  logic [32:0]   lo;

  always_comb begin
    res_d = '0;
    sat_d = 1'b0;
    all_t = 1'b1;
    all_f = 1'b1;
    lo    = '0;
    case (ins[4:3])
      2'b00: for (int i = 0; i < VW/8; i++) begin
        lo = lane_op({24'b0, vra[i*8 +: 8]}, {24'b0, vrb[i*8 +: 8]}, 8, ins[2:0], ins[5], avg_sel);
        res_d[i*8 +: 8] = lo[7:0];
        sat_d = sat_d | lo[32];
        all_t = all_t & lo[0];
        all_f = all_f & ~lo[0];
      end
      2'b01: for (int i = 0; i < VW/16; i++) begin
        lo = lane_op({16'b0, vra[i*16 +: 16]}, {16'b0, vrb[i*16 +: 16]}, 16, ins[2:0], ins[5], avg_sel);
        res_d[i*16 +: 16] = lo[15:0];
        sat_d = sat_d | lo[32];
        all_t = all_t & lo[0];
        all_f = all_f & ~lo[0];
      end
      2'b10: for (int i = 0; i < VW/32; i++) begin
        lo = lane_op(vra[i*32 +: 32], vrb[i*32 +: 32], 32, ins[2:0], ins[5], avg_sel);
        res_d[i*32 +: 32] = lo[31:0];
        sat_d = sat_d | lo[32];
        all_t = all_t & lo[0];
        all_f = all_f & ~lo[0];
      end
      default: ;
    endcase
    cr6_d = ((ins[2:1] == 2'b11) && ins[6] && (ins[4:3] != 2'b11)) ? {all_t, 1'b0, all_f, 1'b0} : 4'b0;
  end

  logic          vld_q [LAT];
  logic [VW-1:0] dat_q [LAT];
  logic          sat_q [LAT];
  logic [3:0]    cr6_q [LAT];
  logic          sticky_q, sticky_d;
  logic          stall;

  assign vrt_en     = vld_q[LAT-1];
  assign vrt        = dat_q[LAT-1];
  assign sat        = sat_q[LAT-1];
  assign cr6        = cr6_q[LAT-1];
  assign sat_sticky = sticky_q;
  assign stall      = vrt_en & ~out_ready;
  assign in_ready   = ~stall;

  // Bubbles carry zeroed payload so an idle output never shows stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
        sat_q[i] <= 1'b0;
        cr6_q[i] <= 4'b0;
      end
    end else if (!stall) begin
      vld_q[0] <= en;
      dat_q[0] <= en ? res_d : '0;
      sat_q[0] <= en & sat_d;
      cr6_q[0] <= en ? cr6_d : 4'b0;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
        sat_q[i] <= sat_q[i-1];
        cr6_q[i] <= cr6_q[i-1];
      end
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    if (vrt_en && out_ready && sat) sticky_d = 1'b1;
    else if (sat_clr)               sticky_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

endmodule
